// File: rtl/corr_pkg.sv
// Shared widths, detector state encoding and the saturating magnitude helper
// for the correlator peak/timestamp back end.
package corr_pkg;

  localparam int CORR_W_DEF = 24;
  localparam int TIM_W_DEF  = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // |x| for a default-width sample; the most negative code clamps to full scale.
  function automatic logic [CORR_W_DEF-2:0] abs_sat(input logic signed [CORR_W_DEF-1:0] x);
    logic [CORR_W_DEF-1:0] a;
    a = x[CORR_W_DEF-1] ? (~x + {{(CORR_W_DEF-1){1'b0}}, 1'b1}) : x;
    return a[CORR_W_DEF-1] ? {(CORR_W_DEF-1){1'b1}} : a[CORR_W_DEF-2:0];
  endfunction

endpackage

// File: rtl/corr_mag.sv
// Combinational saturating magnitude of a signed correlator sample:
// CORR_W-bit two's complement in, CORR_W-1-bit unsigned magnitude out.
module corr_mag #(
  parameter int CORR_W = 24
) (
  input  logic signed [CORR_W-1:0] x,
  output logic        [CORR_W-2:0] mag
);

  logic [CORR_W-1:0] abs_s;

  // The top bit of the negated value is set only for the most negative code.
  always_comb begin
    if (x[CORR_W-1]) begin
      abs_s = ~x + {{(CORR_W-1){1'b0}}, 1'b1};
    end else begin
      abs_s = x;
    end
    if (abs_s[CORR_W-1]) begin
      mag = {(CORR_W-1){1'b1}};
    end else begin
      mag = abs_s[CORR_W-2:0];
    end
  end

endmodule

// File: rtl/corr_peak_timer.sv
// Threshold detector and timestamp unit: reports first crossing or windowed
// maximum of |corr_in| with its sample index, under a rdy/ack handshake.
module corr_peak_timer
  import corr_pkg::*;
#(
  parameter int CORR_W  = CORR_W_DEF,
  parameter int TIM_W   = TIM_W_DEF,
  parameter int WIN_LEN = 16,
  parameter int HOLDOFF = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [CORR_W-1:0] corr_in,
  input  logic              corr_vld,
  input  logic [CORR_W-2:0] thresh,
  input  logic              mode,
  input  logic              ack,
  output logic [TIM_W-1:0]  tim,
  output logic [CORR_W-2:0] peak,
  output logic              rdy,
  output logic              miss
);

  localparam int CNT_MAX = (WIN_LEN > HOLDOFF) ? WIN_LEN : HOLDOFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WIN_INIT  = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF);

  state_e            state_q, state_d;
  logic [TIM_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIM_W-1:0]  tim_q, tim_d;
  logic [CORR_W-2:0] peak_q, peak_d;
  logic              rdy_q, rdy_d;
  logic              miss_q, miss_d;
  logic [CORR_W-2:0] mag_s;
  logic              sample_s;
  logic              cross_s;

  corr_mag #(.CORR_W(CORR_W)) u_mag (
    .x   (corr_in),
    .mag (mag_s)
  );

  assign sample_s = ena & corr_vld;
  assign cross_s  = sample_s & (mag_s > thresh);

  // cnt_q holds the samples still to consume in SEARCH (window) or HOLD (hold-off).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tim_d   = tim_q;
    peak_d  = peak_q;
    rdy_d   = rdy_q;
    miss_d  = 1'b0;
    idx_d   = sample_s ? (idx_q + {{(TIM_W-1){1'b0}}, 1'b1}) : idx_q;
    case (state_q)
      IDLE: begin
        if (cross_s) begin
          tim_d  = idx_q;
          peak_d = mag_s;
          if (!mode || (WIN_LEN == 1)) begin
            state_d = REPORT;
            rdy_d   = 1'b1;
          end else begin
            state_d = SEARCH;
            cnt_d   = WIN_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (sample_s) begin
          if (mag_s > peak_q) begin
            tim_d  = idx_q;
            peak_d = mag_s;
          end else begin
            peak_d = peak_q;
          end
          if (cnt_q == CNT_ONE) begin
            state_d = REPORT;
            rdy_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = SEARCH;
        end
      end
      REPORT: begin
        miss_d = cross_s;
        if (ena && ack) begin
          rdy_d   = 1'b0;
          state_d = (HOLDOFF == 0) ? IDLE : HOLD;
          cnt_d   = HOLD_INIT;
        end else begin
          rdy_d = 1'b1;
        end
      end
      HOLD: begin
        if (sample_s) begin
          if (cnt_q == CNT_ONE) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // State register; ena=0 freezes everything, rst overrides ena.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= {TIM_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      tim_q   <= {TIM_W{1'b0}};
      peak_q  <= {(CORR_W-1){1'b0}};
      rdy_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tim_q   <= tim_d;
      peak_q  <= peak_d;
      rdy_q   <= rdy_d;
      miss_q  <= miss_d;
    end
  end

  assign tim  = tim_q;
  assign peak = peak_q;
  assign rdy  = rdy_q;
  assign miss = miss_q;

endmodule
